// File: rtl/md5_pkg.sv
// ============================================================================
// Module      : md5_pkg
// Description : Shared types and constants for the MD5 block builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md5_pkg;

    localparam int MD5_BLOCK_WIDTH = 512;

    typedef logic [7:0]                 byte_t;
    typedef logic [MD5_BLOCK_WIDTH-1:0] block_t;
    typedef logic [3:0]                 bcd_digit_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BUILD = 2'd1;
    localparam state_t ST_OFFER = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam byte_t C_ASCII_ZERO = 8'h30;
    localparam byte_t C_PAD_BYTE   = 8'h80;

endpackage

`default_nettype wire

// File: rtl/bcd_counter.sv
// ============================================================================
// Module      : bcd_counter
// Description : Variable-length BCD counter; digit 0 is least significant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter
    import md5_pkg::*;
#(
    parameter int MAX_DIGITS = 8,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_inc,
    output logic [MAX_DIGITS*4-1:0] o_digits,
    output logic [CW-1:0]           o_count,
    output logic                    o_overflow
);

    logic [MAX_DIGITS*4-1:0] r_digits;
    logic [CW-1:0]           r_count;
    logic [MAX_DIGITS*4-1:0] w_next;
    logic [CW-1:0]           w_next_count;
    logic                    w_carry;

    // Carry ripples through the live digits; reaching the first unused digit
    // turns it into a new leading '1'. A carry left over means no room.
    always_comb begin
        w_next       = r_digits;
        w_next_count = r_count;
        w_carry      = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (CW'(i) < r_count) begin
                if (w_carry) begin
                    if (r_digits[4*i +: 4] == 4'd9) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end else if ((CW'(i) == r_count) && w_carry) begin
                w_next[4*i +: 4] = 4'd1;
                w_next_count     = r_count + CW'(1);
                w_carry          = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_digits <= {{(MAX_DIGITS*4-4){1'b0}}, 4'd1};
            r_count  <= CW'(1);
        end else if (i_inc && !w_carry) begin
            r_digits <= w_next;
            r_count  <= w_next_count;
        end
    end

    assign o_digits   = r_digits;
    assign o_count    = r_count;
    assign o_overflow = w_carry;

endmodule

`default_nettype wire

// File: rtl/md5_block_builder.sv
// ============================================================================
// Module      : md5_block_builder
// Description : Builds padded MD5 blocks of key || decimal counter suffix.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md5_block_builder
    import md5_pkg::*;
#(
    parameter int BLOCK_WIDTH   = 512,
    parameter int KEY_MAX_BYTES = 16,
    parameter int MAX_DIGITS    = 8,
    parameter int NUMBER_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [7:0]              key_data,
    input  logic                    key_last,
    input  logic                    stop,
    input  logic                    md5_block_ready,
    output logic                    md5_block_valid,
    output logic [BLOCK_WIDTH-1:0]  md5_block_data,
    output logic [NUMBER_WIDTH-1:0] md5_block_number,
    output logic                    busy,
    output logic                    exhausted
);

    localparam int BYTES = BLOCK_WIDTH / 8;
    localparam int BIW   = $clog2(BYTES);
    localparam int KLW   = $clog2(KEY_MAX_BYTES + 1);
    localparam int KIW   = (KEY_MAX_BYTES > 1) ? $clog2(KEY_MAX_BYTES) : 1;
    localparam int CW    = $clog2(MAX_DIGITS + 1);

    state_t                  r_state;
    byte_t                   r_key [KEY_MAX_BYTES];
    logic [KLW-1:0]          r_key_len;
    logic                    r_valid;
    logic [BLOCK_WIDTH-1:0]  r_block;
    logic [NUMBER_WIDTH-1:0] r_number;
    logic                    r_exhausted;

    logic [MAX_DIGITS*4-1:0] w_digits;
    logic [CW-1:0]           w_cnt;
    logic                    w_overflow;
    logic                    w_load;
    logic                    w_inc;
    logic                    w_xfer;
    byte_t                   w_msg [BYTES];
    logic [BIW-1:0]          w_len;
    logic [BIW-1:0]          w_pos;
    logic [63:0]             w_bitlen;
    logic [BLOCK_WIDTH-1:0]  w_block;

    assign w_load = (r_state == ST_IDLE) && key_valid && key_last;
    assign w_xfer = (r_state == ST_OFFER) && r_valid && md5_block_ready;
    assign w_inc  = w_xfer && !stop;

    bcd_counter #(
        .MAX_DIGITS (MAX_DIGITS),
        .CW         (CW)
    ) u_bcd (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_inc      (w_inc),
        .o_digits   (w_digits),
        .o_count    (w_cnt),
        .o_overflow (w_overflow)
    );

    // Message is key then suffix digits (most significant first), 0x80 pad,
    // and the bit length little-endian in the last eight bytes.
    always_comb begin
        for (int b = 0; b < BYTES; b++) begin
            w_msg[b] = '0;
        end
        for (int k = 0; k < KEY_MAX_BYTES; k++) begin
            if (KLW'(k) < r_key_len) begin
                w_msg[k] = r_key[k];
            end
        end
        w_len = BIW'(r_key_len) + BIW'(w_cnt);
        w_pos = '0;
        for (int d = 0; d < MAX_DIGITS; d++) begin
            if (CW'(d) < w_cnt) begin
                w_pos        = w_len - BIW'(1) - BIW'(d);
                w_msg[w_pos] = C_ASCII_ZERO | {4'h0, w_digits[4*d +: 4]};
            end
        end
        w_msg[w_len] = C_PAD_BYTE;
        w_bitlen     = {{(64-BIW-3){1'b0}}, w_len, 3'b000};
        for (int b = 0; b < 8; b++) begin
            w_msg[BYTES-8+b] = w_bitlen[8*b +: 8];
        end
        w_block = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_block[8*b +: 8] = w_msg[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_key_len   <= '0;
            r_valid     <= 1'b0;
            r_block     <= '0;
            r_number    <= '0;
            r_exhausted <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        if (r_key_len < KLW'(KEY_MAX_BYTES)) begin
                            r_key[r_key_len[KIW-1:0]] <= key_data;
                            r_key_len                 <= r_key_len + KLW'(1);
                        end
                        if (key_last) begin
                            r_number <= NUMBER_WIDTH'(1);
                            r_state  <= ST_BUILD;
                        end
                    end
                end
                ST_BUILD: begin
                    if (stop) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_block <= w_block;
                        r_valid <= 1'b1;
                        r_state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        if (stop) begin
                            r_state <= ST_DONE;
                        end else if (w_overflow) begin
                            r_exhausted <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_number <= r_number + NUMBER_WIDTH'(1);
                            r_state  <= ST_BUILD;
                        end
                    end else if (stop) begin
                        r_valid <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign md5_block_valid  = r_valid;
    assign md5_block_data   = r_block;
    assign md5_block_number = r_number;
    assign busy             = (r_state == ST_BUILD) || (r_state == ST_OFFER);
    assign exhausted        = r_exhausted;

endmodule

`default_nettype wire
